// File: rtl/uart_rx_sipo_if.sv
// Receiver-side bundle: the serial line in, the recovered byte and its status out.
interface uart_rx_sipo_if;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       active_flag;

    // Line driver / byte consumer side
    modport master (
        output rx_in,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  active_flag
    );

    // Receiver side
    modport slave (
        input  rx_in,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output active_flag
    );
endinterface

// File: rtl/uart_rx_sipo.sv
// Oversampling UART receiver: start, 8 data bits LSB first, parity, stop.
// Recovers the byte, checks parity and stop bit, pulses data_valid per frame.
module uart_rx_sipo #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic          baud_clk,
    input  logic          reset_n,
    uart_rx_sipo_if.slave bus
);

    localparam int unsigned     CntW    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4,
        StBreak  = 3'd5
    } state_e;

    state_e          r_state, w_state_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_bit_idx, w_bit_idx_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_par, w_par_nxt;
    logic [7:0]      r_data, w_data_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_perr, w_perr_nxt;
    logic            r_ferr, w_ferr_nxt;
    logic            r_sync1, r_sync2;
    logic            w_rx_s;
    logic            w_sample;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s   = r_sync2;
    assign w_sample = (r_cnt == CntLast);

    // State, counters and output registers
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_par     <= w_par_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_perr    <= w_perr_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    // Next-state and frame bookkeeping; all bit decisions use the synchronized line
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_par_nxt     = r_par;
        w_data_nxt    = r_data;
        w_valid_nxt   = 1'b0;
        w_perr_nxt    = r_perr;
        w_ferr_nxt    = r_ferr;

        unique case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = StStart;
                end
            end
            StStart: begin
                // Confirm the start bit at its midpoint; a high line here was a glitch
                if (r_cnt == CntHalf) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = w_rx_s ? StIdle : StData;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StData: begin
                if (w_sample) begin
                    w_cnt_nxt              = '0;
                    w_shift_nxt[r_bit_idx] = w_rx_s;
                    w_bit_idx_nxt          = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = StParity;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StParity: begin
                if (w_sample) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = w_rx_s;
                    w_state_nxt = StStop;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StStop: begin
                // Errored frames still publish; the consumer qualifies with the flags
                if (w_sample) begin
                    w_cnt_nxt   = '0;
                    w_data_nxt  = r_shift;
                    w_valid_nxt = 1'b1;
                    w_perr_nxt  = (^{r_shift, r_par}) ^ PARITY_ODD;
                    w_ferr_nxt  = ~w_rx_s;
                    w_state_nxt = w_rx_s ? StIdle : StBreak;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StBreak: begin
                // Line held low past the stop bit: ignore it until it returns high
                w_cnt_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign bus.data_out    = r_data;
    assign bus.data_valid  = r_valid;
    assign bus.parity_err  = r_perr;
    assign bus.frame_err   = r_ferr;
    assign bus.active_flag = (r_state == StStart) || (r_state == StData) ||
                             (r_state == StParity) || (r_state == StStop);

endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
- Serial-in/parallel-out UART receiver.
- Consumes the 11-bit frame produced by the transmit PISO:
  - start bit 0
  - 8 data bits, LSB first
  - 1 parity bit
  - stop bit 1
- Oversamples the line, recovers the byte, checks parity and stop bit, and presents the byte with a one-cycle valid pulse to the command/telemetry logic downstream.

Parameters:
- OVERSAMPLE, 16: baud_clk cycles per serial bit. Must be even and ≥4.
- PARITY_ODD, 0: 0 = even parity expected, 1 = odd parity expected.

Ports:
- baud_clk  in  1  receive sampling clock, OVERSAMPLE × bit rate.
- reset_n  in  1  asynchronous active-low reset.
- rx_in  in  1  serial line, asynchronous to baud_clk, idles high.
- data_out  out  8  last received byte.
- data_valid  out  1  one-cycle pulse when a frame completes.
- parity_err  out  1  parity mismatch on last frame.
- frame_err  out  1  stop bit sampled low on last frame.
- active_flag  out  1  high while a frame is being received.

Behaviour:
- Reset (async, on reset_n low, including mid-frame):
  - state = IDLE.
  - Synchronizer flops = 1.
  - data_out = 0x00; data_valid, parity_err, frame_err, active_flag = 0.
  - All counters = 0.
- Synchronizer: rx_in passes through 2 flops to give rx_s. All decisions use rx_s only.
- Counters:
  - cnt: ceil(log2(OVERSAMPLE)) bits.
  - bit_idx: 3 bits.
  - shift register: 8 bits.
  - parity bit register: 1 bit.
- IDLE:
  - active_flag = 0; cnt = 0.
  - rx_s == 0 at an edge (call it edge D) → START.
- START:
  - cnt increments each cycle.
  - At edge D + OVERSAMPLE/2, i.e. the start-bit midpoint, sample rx_s:
    - rx_s == 0 → DATA, cnt = 0, bit_idx = 0.
    - rx_s == 1 → false start (glitch), back to IDLE. No outputs change.
- DATA:
  - Sample every OVERSAMPLE cycles, at the edge where cnt == OVERSAMPLE−1; cnt wraps to 0.
  - Write rx_s into shift bit[bit_idx] (LSB first).
  - After bit_idx 7 is sampled → PARITY. bit_idx wraps to 0.
- PARITY: sample one bit period later into the parity register, then → STOP.
- STOP: at the next sample edge, D + OVERSAMPLE/2 + 10·OVERSAMPLE, on that same edge:
  - data_out = shift register.
  - data_valid = 1 for exactly one cycle.
  - parity_err = (^{data, parity_bit}) XOR PARITY_ODD.
  - frame_err = ~rx_s.
  - rx_s == 1 → IDLE.
  - rx_s == 0 → BREAK.
- BREAK:
  - Wait until rx_s == 1, then → IDLE.
  - No new frame is accepted while the line is held low.
  - active_flag = 0.
- active_flag:
  - 1 in START, DATA, PARITY and STOP.
  - Cleared on the edge that leaves STOP.
- Output holding:
  - data_out, parity_err and frame_err hold until the next completed frame overwrites them.
  - A false start never modifies them.
- Back-to-back frames: a new start bit is detected on the first IDLE cycle after STOP. No mandatory idle gap is required beyond the stop bit.
- Errored frames still pulse data_valid. The consumer qualifies the byte with the error flags.
- Latency: rx_in falling edge to data_valid = 2 synchronizer cycles + 1 detect cycle + OVERSAMPLE/2 + 10·OVERSAMPLE cycles, with ±1 cycle for input phase. With OVERSAMPLE=16 this is 171 ±1 cycles.

Test Plan:
- Reset, line idle high for 50 cycles → all outputs 0, active_flag 0, no data_valid pulse.
- Frame 0xA5, parity bit 0 (even), stop bit 1, 16 cycles/bit:
  - data_out = 0xA5.
  - One data_valid pulse at 171 ±1 cycles after the falling edge.
  - parity_err = 0, frame_err = 0.
  - active_flag high throughout the frame.
- Frame 0x3C with parity bit 1 → data_out = 0x3C, parity_err = 1, frame_err = 0. With PARITY_ODD=1 the same frame gives parity_err = 0.
- Frame 0x81 with stop bit 0, line then held low 40 cycles before rising:
  - data_out = 0x81, frame_err = 1.
  - Block stays in BREAK with no second data_valid pulse until the line rises.
  - A following frame 0x55 is received correctly.
- Glitches:
  - 5-cycle low glitch on the idle line → no active_flag beyond START, no data_valid, outputs unchanged.
  - Reset asserted mid-DATA → all outputs and state return to reset values immediately.
  - A subsequent 0x7E frame after release is received correctly.
- Back-to-back frames 0x00 then 0xFF, no idle gap → two data_valid pulses exactly 11·16 = 176 cycles apart, with correct data and no errors.
